booth_mul_iter: RTL and testbench

//  Iterative radix-4 Booth multiplier for the EX-stage MUL/MULH/MULHU path.

---
 rtl/booth_mul_iter_pkg.sv | 34 +++
 rtl/booth_mul_iter_if.sv | 25 ++
 rtl/booth_pp_sel.sv | 27 ++
 rtl/booth_mul_iter.sv | 146 ++++++++++++++
 tb/tb_booth_mul_iter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/booth_mul_iter_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// FSM encoding, Booth digit codes and derived-size helpers.
package booth_mul_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Radix-4 Booth digit codes {y[2k+1], y[2k], y[2k-1]}
  localparam logic [2:0] BD_ZERO   = 3'b000;
  localparam logic [2:0] BD_P1_A   = 3'b001;
  localparam logic [2:0] BD_P1_B   = 3'b010;
  localparam logic [2:0] BD_P2     = 3'b011;
  localparam logic [2:0] BD_M2     = 3'b100;
  localparam logic [2:0] BD_M1_A   = 3'b101;
  localparam logic [2:0] BD_M1_B   = 3'b110;
  localparam logic [2:0] BD_ZERO_N = 3'b111;

  // Extended operand width: room for the unsigned MSB plus a sign bit.
  function automatic int booth_ew(input int width);
    return width + 2;
  endfunction

  function automatic int booth_n_dig(input int width);
    return (width + 2) / 2;
  endfunction

  function automatic int booth_cycles(input int width, input int dpc);
    return (booth_n_dig(width) + dpc - 1) / dpc;
  endfunction

endpackage

// File: rtl/booth_mul_iter_if.sv
// Request/response bundle between the EX stage and the Booth multiplier.
interface booth_mul_iter_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               mul_signed;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               cancel;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, mul_signed, x, y, cancel, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, mul_signed, x, y, cancel, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: maps one 3-bit digit to
// 0, +-X or +-2X, sign-extended to EW+1 bits.
module booth_pp_sel
  import booth_mul_iter_pkg::*;
#(
  parameter int EW = 34
) (
  input  logic [2:0]  digit_i,
  input  logic [EW-1:0] x_i,
  input  logic [EW-1:0] nx_i,
  output logic [EW:0]   pp_o
);

  // Digit decode; 2X is a plain left shift because X already has a spare sign bit
  always_comb begin
    pp_o = '0;
    case (digit_i)
      BD_ZERO, BD_ZERO_N: pp_o = '0;
      BD_P1_A, BD_P1_B:   pp_o = {x_i[EW-1], x_i};
      BD_P2:              pp_o = {x_i, 1'b0};
      BD_M2:              pp_o = {nx_i, 1'b0};
      BD_M1_A, BD_M1_B:   pp_o = {nx_i[EW-1], nx_i};
      default:            pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHU), DIGITS_PER_CYCLE
// digits per BUSY cycle, valid/ready on both sides, flushable via cancel.
module booth_mul_iter
  import booth_mul_iter_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  booth_mul_iter_if.slave  mul_if
);

  localparam int EW    = booth_ew(WIDTH);
  localparam int N_DIG = booth_n_dig(WIDTH);
  localparam int C     = booth_cycles(WIDTH, DIGITS_PER_CYCLE);
  localparam int AW    = 2 * EW;
  localparam int PW    = EW + 1;
  localparam int YW    = EW + 1;
  localparam int CNT_W = (C > 1) ? $clog2(C + 1) : 1;
  localparam int KW    = $clog2(N_DIG + DIGITS_PER_CYCLE) + 1;

  state_e             state_q, state_d;
  logic [EW-1:0]      x_q, x_d;
  logic [EW-1:0]      nx_q, nx_d;
  logic [YW-1:0]      y_q, y_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               x_sign_s, y_sign_s;
  logic [EW-1:0]      x_ext_s, y_ext_s;
  logic [AW-1:0]      pp_sh_s [DIGITS_PER_CYCLE];
  logic [AW-1:0]      pp_sum_s;
  logic [AW-1:0]      acc_next_s;

  assign x_sign_s = mul_if.mul_signed & mul_if.x[WIDTH-1];
  assign y_sign_s = mul_if.mul_signed & mul_if.y[WIDTH-1];
  assign x_ext_s  = {{2{x_sign_s}}, mul_if.x};
  assign y_ext_s  = {{2{y_sign_s}}, mul_if.y};

  // Digit j of this cycle has global index k = cnt*DPC + j; indices past the
  // last real digit would read shifted-in filler, so they are forced to zero.
  for (genvar j = 0; j < DIGITS_PER_CYCLE; j++) begin : g_dig
    logic [KW-1:0] k_s;
    logic [2:0]    dig_s;
    logic [PW-1:0] pp_s;

    assign k_s   = KW'(cnt_q) * KW'(DIGITS_PER_CYCLE) + KW'(j);
    assign dig_s = (k_s < KW'(N_DIG)) ? y_q[2*j+2 -: 3] : BD_ZERO;

    booth_pp_sel #(.EW(EW)) u_pp_sel (
      .digit_i (dig_s),
      .x_i     (x_q),
      .nx_i    (nx_q),
      .pp_o    (pp_s)
    );

    assign pp_sh_s[j] = {{(AW-PW){pp_s[PW-1]}}, pp_s} << {k_s, 1'b0};
  end

  // Sum of this cycle's weighted partial products
  always_comb begin
    pp_sum_s = '0;
    for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
      pp_sum_s = pp_sum_s + pp_sh_s[j];
    end
  end

  assign acc_next_s = acc_q + pp_sum_s;

  // Next-state and datapath update; cancel overrides every transition
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    nx_d    = nx_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    if (mul_if.cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mul_if.in_valid) begin
            state_d = ST_BUSY;
            x_d     = x_ext_s;
            nx_d    = -x_ext_s;
            y_d     = {y_ext_s, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          acc_d = acc_next_s;
          y_d   = y_q >> (2 * DIGITS_PER_CYCLE);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(C - 1)) begin
            state_d = ST_DONE;
            prod_d  = acc_next_s[2*WIDTH-1:0];
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (mul_if.out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      nx_q    <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      nx_q    <= nx_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign mul_if.in_ready  = (state_q == ST_IDLE);
  assign mul_if.out_valid = (state_q == ST_DONE);
  assign mul_if.busy      = (state_q != ST_IDLE);
  assign mul_if.product   = prod_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Directed bench for booth_mul_iter: one DUT with 1 digit/cycle and one with
// 4 digits/cycle share the request stimulus; results are hand-computed.
module tb_booth_mul_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        mul_signed;
  logic        cancel;
  logic        out_ready1;
  logic        out_ready4;
  logic [31:0] x;
  logic [31:0] y;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  booth_mul_iter_if #(.WIDTH(32)) if1 ();
  booth_mul_iter_if #(.WIDTH(32)) if4 ();

  assign if1.in_valid   = in_valid;
  assign if1.mul_signed = mul_signed;
  assign if1.x          = x;
  assign if1.y          = y;
  assign if1.cancel     = cancel;
  assign if1.out_ready  = out_ready1;
  assign if4.in_valid   = in_valid;
  assign if4.mul_signed = mul_signed;
  assign if4.x          = x;
  assign if4.y          = y;
  assign if4.cancel     = cancel;
  assign if4.out_ready  = out_ready4;

  booth_mul_iter #(.WIDTH(32), .DIGITS_PER_CYCLE(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .mul_if (if1)
  );

  booth_mul_iter #(.WIDTH(32), .DIGITS_PER_CYCLE(4)) dut4 (
    .clk    (clk),
    .reset  (reset),
    .mul_if (if4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one op in cycle 0 and check latency (18 / 6) and product on both DUTs.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int seen1;
    int seen4;
    seen1 = 0;
    seen4 = 0;
    @(negedge clk);
    check({tag, "/rdy"}, {62'd0, if1.in_ready, if4.in_ready}, 64'd3);
    mul_signed = sgn;
    x          = a;
    y          = b;
    in_valid   = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid   = 1'b0;
        x          = $urandom;
        y          = $urandom;
        mul_signed = ~sgn;
      end
      out_ready1 = 1'b0;
      out_ready4 = 1'b0;
      if (seen1 == 0 && if1.out_valid) begin
        seen1 = n;
        check({tag, "/p1"}, if1.product, exp);
        out_ready1 = 1'b1;
      end
      if (seen4 == 0 && if4.out_valid) begin
        seen4 = n;
        check({tag, "/p4"}, if4.product, exp);
        out_ready4 = 1'b1;
      end
      if (seen1 != 0 && seen4 != 0) break;
    end
    check({tag, "/lat1"}, 64'(seen1), 64'd18);
    check({tag, "/lat4"}, 64'(seen4), 64'd6);
    @(negedge clk);
    out_ready1 = 1'b0;
    out_ready4 = 1'b0;
  endtask

  // Start an op on both DUTs and advance to the negedge of cycle ncyc.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input int ncyc);
    @(negedge clk);
    mul_signed = 1'b0;
    x          = a;
    y          = b;
    in_valid   = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic saw;
    reset      = 1'b1;
    in_valid   = 1'b0;
    mul_signed = 1'b0;
    cancel     = 1'b0;
    out_ready1 = 1'b0;
    out_ready4 = 1'b0;
    x          = 32'd0;
    y          = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // flags are {out_valid, in_ready, busy}
    check("rst/flags1", {61'd0, if1.out_valid, if1.in_ready, if1.busy}, 64'd2);
    check("rst/flags4", {61'd0, if4.out_valid, if4.in_ready, if4.busy}, 64'd2);
    check("rst/prod1", if1.product, 64'd0);
    check("rst/prod4", if4.product, 64'd0);

    run_op("s_m3x7",   1'b1, 32'hFFFFFFFD, 32'd7,       64'hFFFFFFFFFFFFFFEB);
    run_op("u_ffxff",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    run_op("s_ffxff",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
    run_op("s_minsq",  1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    run_op("u_minsq",  1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    run_op("s_maxmin", 1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000);
    run_op("u_minmax", 1'b0, 32'h80000000, 32'h7FFFFFFF, 64'h3FFFFFFF80000000);
    run_op("u_ffx2",   1'b0, 32'hFFFFFFFF, 32'd2,        64'h00000001FFFFFFFE);
    run_op("s_zero",   1'b1, 32'd0,        32'hFFFFFFFF, 64'd0);

    // Backpressure on the 1-digit DUT; the 4-digit one drains freely.
    out_ready4 = 1'b1;
    start_and_wait(32'd5, 32'd6, 18);
    check("bp/prod0", if1.product, 64'd30);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("bp/flags", {61'd0, if1.out_valid, if1.in_ready, if1.busy}, 64'd5);
      check("bp/prod", if1.product, 64'd30);
    end
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("bp/after", {61'd0, if1.out_valid, if1.in_ready, if1.busy}, 64'd2);

    // Cancel in BUSY cycle 8: no result, IDLE in cycle 9.
    start_and_wait(32'd9, 32'd9, 8);
    check("cnl/busy8", {63'd0, if1.busy}, 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cnl/c9", {61'd0, if1.out_valid, if1.in_ready, if1.busy}, 64'd2);
    saw = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (if1.out_valid) saw = 1'b1;
    end
    check("cnl/noval", {63'd0, saw}, 64'd0);
    out_ready4 = 1'b0;
    run_op("cnl_new", 1'b1, 32'd12345, 32'hFFFFFD5A, 64'hFFFFFFFFFF80490A);

    // Cancel together with in_valid in IDLE: nothing is accepted.
    @(negedge clk);
    cancel   = 1'b1;
    in_valid = 1'b1;
    x        = 32'd3;
    y        = 32'd3;
    @(negedge clk);
    cancel   = 1'b0;
    in_valid = 1'b0;
    check("cnl/idle", {61'd0, if1.out_valid, if1.in_ready, if1.busy}, 64'd2);

    // Cancel in DONE while held: result dropped, back to IDLE.
    out_ready4 = 1'b1;
    start_and_wait(32'd4, 32'd4, 19);
    check("cnl/done", {61'd0, if1.out_valid, if1.in_ready, if1.busy}, 64'd5);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cnl/done2", {61'd0, if1.out_valid, if1.in_ready, if1.busy}, 64'd2);
    out_ready4 = 1'b0;

    // Reset in cycle 3 of an op, then a fresh op.
    start_and_wait(32'd100, 32'd100, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst/flags1", {61'd0, if1.out_valid, if1.in_ready, if1.busy}, 64'd2);
    check("mrst/flags4", {61'd0, if4.out_valid, if4.in_ready, if4.busy}, 64'd2);
    check("mrst/prod1", if1.product, 64'd0);
    check("mrst/prod4", if4.product, 64'd0);
    run_op("post_rst", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFA, 64'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
